// File: rtl/param_deserializer_pkg.sv
// Shared UART definitions used by the Rx deserializer and the Tx serializer.
//   DEFAULT_MAX_WIDTH : default widest word in bits
//   bit_order_e       : serial bit order (LSB_FIRST is the UART default)
//   clamp_length      : maps a requested word length onto the legal range
package param_deserializer_pkg;

    localparam int DEFAULT_MAX_WIDTH = 9;

    typedef enum logic {
        LSB_FIRST = 1'b0,
        MSB_FIRST = 1'b1
    } bit_order_e;

    // A length of 0, or anything wider than the datapath, selects the full width.
    function automatic int unsigned clamp_length(input int unsigned len,
                                                 input int unsigned max_len);
        if ((len == 0) || (len > max_len)) begin
            return max_len;
        end
        return len;
    endfunction

endpackage

// File: rtl/param_deserializer_if.sv
// Bus between the Rx FSM/sampler (master) and the deserializer (slave).
//   enable, clear, data_in      : shift strobe, word abort, serial bit
//   data_length, msb_first      : word length and bit order for the next word
//   data_out, data_valid, parity: completed word, one-cycle strobe, XOR of word
//   busy, bit_count             : progress through the current word
interface param_deserializer_if
    import param_deserializer_pkg::*;
#(
    parameter int MAX_WIDTH = DEFAULT_MAX_WIDTH,
    parameter int CNT_WIDTH = $clog2(MAX_WIDTH + 1)
);

    logic                 enable;
    logic                 clear;
    logic                 data_in;
    logic [CNT_WIDTH-1:0] data_length;
    logic                 msb_first;
    logic [MAX_WIDTH-1:0] data_out;
    logic                 data_valid;
    logic                 parity;
    logic                 busy;
    logic [CNT_WIDTH-1:0] bit_count;

    modport master (
        output enable, clear, data_in, data_length, msb_first,
        input  data_out, data_valid, parity, busy, bit_count
    );

    modport slave (
        input  enable, clear, data_in, data_length, msb_first,
        output data_out, data_valid, parity, busy, bit_count
    );

endinterface

// File: rtl/param_deserializer_bit_counter.sv
// Bit counter for the deserializer: counts captured bits, latches word length
// and bit order at the start of each word, and flags word completion.
//   clock, reset      : rising-edge clock, synchronous active-low reset
//   enable, clear     : shift strobe, word abort
//   data_length       : requested length (clamped when latched)
//   msb_first         : requested order (latched with the length)
//   bit_count, busy   : registered progress
//   word_len          : length in force for this cycle's enable
//   word_order        : order in force for this cycle's enable
//   word_done         : this enable captures the last bit of the word
//
// state   | meaning
// EMPTY   | bit_count == 0, next enable or clear latches length/order
// FILLING | 0 < bit_count < latched length, length/order frozen
module deser_bit_counter
    import param_deserializer_pkg::*;
#(
    parameter int MAX_WIDTH = DEFAULT_MAX_WIDTH,
    parameter int CNT_WIDTH = $clog2(MAX_WIDTH + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [CNT_WIDTH-1:0] data_length,
    input  logic                 msb_first,
    output logic [CNT_WIDTH-1:0] bit_count,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] word_len,
    output bit_order_e           word_order,
    output logic                 word_done
);

    logic [CNT_WIDTH-1:0] bit_count_q, bit_count_d;
    logic [CNT_WIDTH-1:0] len_q, len_d;
    bit_order_e           order_q, order_d;
    logic                 busy_q, busy_d;
    logic                 latch_now;
    logic [CNT_WIDTH-1:0] count_base;
    logic [CNT_WIDTH-1:0] count_inc;

    always_comb begin
        len_d       = len_q;
        order_d     = order_q;
        bit_count_d = bit_count_q;

        // Clear starts a new word from any state, so it latches too.
        latch_now = clear | (enable & (bit_count_q == '0));
        if (latch_now) begin
            len_d   = CNT_WIDTH'(clamp_length(32'(data_length), unsigned'(MAX_WIDTH)));
            order_d = bit_order_e'(msb_first);
        end

        // With clear and enable together the incoming bit is bit 1 of a fresh word.
        count_base = clear ? '0 : bit_count_q;
        count_inc  = count_base + CNT_WIDTH'(1);
        word_done  = enable & (count_inc == len_d);

        if (enable) begin
            bit_count_d = word_done ? '0 : count_inc;
        end else if (clear) begin
            bit_count_d = '0;
        end

        busy_d = (bit_count_d != '0);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            bit_count_q <= '0;
            len_q       <= CNT_WIDTH'(MAX_WIDTH);
            order_q     <= LSB_FIRST;
            busy_q      <= 1'b0;
        end else begin
            bit_count_q <= bit_count_d;
            len_q       <= len_d;
            order_q     <= order_d;
            busy_q      <= busy_d;
        end
    end

    assign bit_count  = bit_count_q;
    assign busy       = busy_q;
    assign word_len   = len_d;
    assign word_order = order_d;

endmodule

// File: rtl/param_deserializer.sv
// Parametrised serial-to-parallel converter for the UART receive path.
// Shifts one bit per enable, emits a right-justified word with a one-cycle
// valid pulse and its parity once the latched word length has been captured.
//   clock : rising-edge system clock
//   reset : synchronous active-low reset
//   des   : slave side of param_deserializer_if (MAX_WIDTH/CNT_WIDTH must
//           match the interface instance)
module param_deserializer
    import param_deserializer_pkg::*;
#(
    parameter int MAX_WIDTH = DEFAULT_MAX_WIDTH,
    parameter int CNT_WIDTH = $clog2(MAX_WIDTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    param_deserializer_if.slave   des
);

    logic [MAX_WIDTH-1:0] shift_reg_q, shift_reg_d;
    logic [MAX_WIDTH-1:0] shift_base;
    logic [MAX_WIDTH-1:0] data_out_q, data_out_d;
    logic [MAX_WIDTH-1:0] aligned;
    logic [MAX_WIDTH-1:0] len_mask;
    logic [CNT_WIDTH-1:0] pad;
    logic                 parity_q, parity_d;
    logic                 data_valid_q, data_valid_d;

    logic [CNT_WIDTH-1:0] bit_count;
    logic                 busy;
    logic [CNT_WIDTH-1:0] word_len;
    bit_order_e           word_order;
    logic                 word_done;

    deser_bit_counter #(
        .MAX_WIDTH (MAX_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_bit_counter (
        .clock       (clock),
        .reset       (reset),
        .enable      (des.enable),
        .clear       (des.clear),
        .data_length (des.data_length),
        .msb_first   (des.msb_first),
        .bit_count   (bit_count),
        .busy        (busy),
        .word_len    (word_len),
        .word_order  (word_order),
        .word_done   (word_done)
    );

    always_comb begin
        shift_reg_d  = shift_reg_q;
        data_out_d   = data_out_q;
        parity_d     = parity_q;
        data_valid_d = word_done;

        shift_base = des.clear ? '0 : shift_reg_q;
        if (des.enable) begin
            if (word_order == MSB_FIRST) begin
                shift_reg_d = {shift_base[MAX_WIDTH-2:0], des.data_in};
            end else begin
                shift_reg_d = {des.data_in, shift_base[MAX_WIDTH-1:1]};
            end
        end else if (des.clear) begin
            shift_reg_d = '0;
        end

        // LSB-first words collect at the top of the register, MSB-first at the
        // bottom; stale bits from earlier words are dropped by shift or mask.
        pad      = CNT_WIDTH'(MAX_WIDTH) - word_len;
        len_mask = {MAX_WIDTH{1'b1}} >> pad;
        if (word_order == MSB_FIRST) begin
            aligned = shift_reg_d & len_mask;
        end else begin
            aligned = shift_reg_d >> pad;
        end

        if (word_done) begin
            data_out_d = aligned;
            parity_d   = ^aligned;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            shift_reg_q  <= '0;
            data_out_q   <= '0;
            parity_q     <= 1'b0;
            data_valid_q <= 1'b0;
        end else begin
            shift_reg_q  <= shift_reg_d;
            data_out_q   <= data_out_d;
            parity_q     <= parity_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign des.data_out   = data_out_q;
    assign des.data_valid = data_valid_q;
    assign des.parity     = parity_q;
    assign des.busy       = busy;
    assign des.bit_count  = bit_count;

endmodule

// File: doc/param_deserializer.md
Name: param_deserializer

Overview:
Parametrised serial-to-parallel converter for the UART receive path; next generation of the fixed 8-bit Rx deserializer. It shifts in one bit per enable strobe and has a runtime word length and a selectable LSB-first/MSB-first order. It counts bits itself and emits a right-justified word with a one-cycle valid pulse and a parity bit. Sits between the Rx FSM/sampler (which drives enable and clear) and the parity/stop checker.

Parameters:
MAX_WIDTH, 9, widest supported word in bits (legal 2..16); sets shift register and data_out width.
CNT_WIDTH, $clog2(MAX_WIDTH+1), width of bit counter and data_length.

Ports:
clock  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-low reset.
enable  input  1  shift strobe; sample data_in this cycle.
clear  input  1  abort current word, zero counter (start-of-frame alignment).
data_in  input  1  serial bit.
data_length  input  CNT_WIDTH  word length, latched on clear or at word start.
msb_first  input  1  0 = LSB first (UART default), 1 = MSB first; latched with data_length.
data_out  output  MAX_WIDTH  last completed word, right-justified, upper bits zero.
data_valid  output  1  one-cycle pulse when data_out updates.
parity  output  1  XOR of data_out bits; updates with data_out.
busy  output  1  high while 0 < bit_count < latched length.
bit_count  output  CNT_WIDTH  bits captured in the current word.

Behaviour:
- Reset (reset==0 at a clock edge): shift_reg, bit_count, data_out, parity, data_valid, busy all 0; latched length = MAX_WIDTH, latched order = LSB first.
- Length latch: sampled when bit_count==0 and (enable or clear). data_length==0 or >MAX_WIDTH uses MAX_WIDTH; 1 is legal.
- Order latch: msb_first is latched at the same moment; changes mid-word are ignored.
- LSB-first shift: shift_reg <= {data_in, shift_reg[MAX-1:1]}.
- MSB-first shift: shift_reg <= {shift_reg[MAX-2:0], data_in}.
- Each enable: bit_count +1.
- Word completion, on the enable edge where bit_count+1 == len:
  - LSB-first: data_out <= (new shift_reg) >> (MAX_WIDTH-len).
  - MSB-first: data_out <= new shift_reg masked to len bits.
  - parity <= ^(new data_out); data_valid <= 1 for exactly one cycle; bit_count <= 0 (auto-restart, back-to-back words with no gap cycle).
- No enable: shift_reg and bit_count hold; data_out and parity hold until the next completion.
- Clear without enable: bit_count <= 0, shift_reg <= 0, no data_valid, data_out unchanged.
- Clear with enable in the same cycle: clear wins for the old word, and data_in becomes bit 1 of the new word; bit_count <= 1 (or completes at once if len==1).
- Reset has priority over clear and enable. Reset mid-word discards the partial word with no valid pulse.
- busy = (bit_count != 0), registered with bit_count.
- Latency: data_out/data_valid visible the cycle after the last enable edge.
- State view (implicit in bit_count): EMPTY (0) -> FILLING (1..len-1) -> EMPTY on completion; clear returns to EMPTY from any state.

Decomposition:
- Shared UART package: MAX_WIDTH default, the LSB_FIRST/MSB_FIRST constants, and the length-clamp function (reused by the Tx serializer).
- One sub-module, deser_bit_counter: holds the counter, length/order latches and the completion detect.
- The shift register and output alignment stay in the top module.

Test Plan:
- MAX=9, len=8, LSB-first, bits 1,0,1,0,0,1,0,1 -> data_out=0x0A5, parity=0, data_valid for 1 cycle, bit_count back to 0.
- len=7, MSB-first, bits 1,0,1,0,1,0,1 -> data_out=0x055, parity=0; then len=5 LSB-first, bits 1,1,0,0,1 -> data_out=0x013, parity=1.
- Two len=8 words back to back, enable every cycle, 0xFF then 0x00 -> two valid pulses 8 cycles apart; data_out 0x0FF then 0x000; parity 0 then 0.
- len=8, 3 bits then clear, then 8 bits of 0x3C -> no valid after the 3 bits; one valid with 0x03C; data_out holds the prior value until then.
- Clear and enable together with data_in=1, then 7 more bits 0 (len=8, LSB-first) -> data_out=0x001, parity=1.
- reset low after 5 bits, then 8 bits of 0x81 -> all outputs 0 during reset; then data_out=0x081, parity=0. Also data_length=0 -> 9-bit word.
